// File: rtl/reg_file.sv
// reg_file: single-write, single-read register array backing the LIFO stack.
// The write port is clocked and the read port is purely combinational.
// Addresses at or beyond HEIGHT are treated as "no entry": writes to them
// are ignored and reads from them return zero.
module reg_file #(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 9,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  we
);

    // Highest legal address, sized to the address bus so range checks are
    // plain same-width compares.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(HEIGHT - 1);

    logic [WIDTH-1:0] mem [HEIGHT];
    logic             wr_in_range;
    logic             rd_in_range;

    assign wr_in_range = (waddr <= LAST_ADDR);
    assign rd_in_range = (raddr <= LAST_ADDR);

    // Clear every entry on reset; otherwise write one in-range entry when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HEIGHT; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wr_in_range) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency read; out-of-range addresses (e.g. the empty-stack top) read as zero.
    always_comb begin
        rdata = '0;
        if (rd_in_range) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed bench for reg_file using an expected-value queue
// drained by an independent monitor process.
module tb_reg_file;

    localparam int WIDTH      = 8;
    localparam int HEIGHT     = 9;
    localparam int ADDR_WIDTH = 4;

    logic                  clk;
    logic                  rst_n;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [WIDTH-1:0]      rdata;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [WIDTH-1:0]      wdata;
    logic                  we;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    string            name_q[$];
    event             sample_ev;

    reg_file #(
        .WIDTH(WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .raddr(raddr),
        .rdata(rdata),
        .waddr(waddr),
        .wdata(wdata),
        .we(we)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation ran past its time limit");
        $fatal(1, "[TB] timeout");
    end

    // Monitor: each time stimulus asks for a sample, pop the oldest expectation and compare.
    initial begin
        logic [WIDTH-1:0] exp_v;
        string            nm;
        forever begin
            @(sample_ev);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_underflow: rdata=%h with no expected value queued", rdata);
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (rdata !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL %s: raddr=%0d rdata=%h expected=%h", nm, raddr, rdata, exp_v);
                end
            end
        end
    end

    task automatic applyStimulus(input logic w_en, input logic [ADDR_WIDTH-1:0] wa,
                                 input logic [WIDTH-1:0] wd, input logic [ADDR_WIDTH-1:0] ra);
        we    = w_en;
        waddr = wa;
        wdata = wd;
        raddr = ra;
        #1;
    endtask

    task automatic checkOutput(input string nm, input logic [WIDTH-1:0] exp_v);
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
        ->sample_ev;
        #1;
    endtask

    // Read address a (write disabled) and check against exp_v.
    task automatic readCheck(input string nm, input logic [ADDR_WIDTH-1:0] a,
                             input logic [WIDTH-1:0] exp_v);
        applyStimulus(1'b0, 4'd0, 8'h00, a);
        checkOutput(nm, exp_v);
    endtask

    initial begin
        logic [WIDTH-1:0] model [16];
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        rst_n = 1'b0;
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr = '0;

        // 1. Reset: every address reads zero, both during and after reset.
        repeat (2) @(negedge clk);
        readCheck("in_reset_addr0", 4'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < HEIGHT; a++) readCheck($sformatf("after_reset_addr%0d", a), 4'(a), 8'h00);
        readCheck("after_reset_addr15", 4'd15, 8'h00);

        // 2. Collision: old data before the edge, new data after it.
        @(negedge clk);
        applyStimulus(1'b1, 4'd3, 8'hA5, 4'd3);
        checkOutput("collision_before_edge", 8'h00);
        @(posedge clk);
        #2;
        checkOutput("collision_after_edge", 8'hA5);
        model[3] = 8'hA5;

        // 3. Fill every entry with 0x10+addr, then sweep the whole address space.
        for (int a = 0; a < HEIGHT; a++) begin
            @(negedge clk);
            applyStimulus(1'b1, 4'(a), 8'h10 + 8'(a), 4'(a));
            @(posedge clk);
            model[a] = 8'h10 + 8'(a);
        end
        @(negedge clk);
        for (int a = 0; a < 16; a++) readCheck($sformatf("fill_sweep_addr%0d", a), 4'(a), model[a]);

        // 4. Out-of-range writes (9 and 15) must change nothing and must not alias.
        @(negedge clk);
        applyStimulus(1'b1, 4'd9, 8'hFF, 4'd1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 4'd15, 8'hEE, 4'd1);
        @(posedge clk);
        @(negedge clk);
        readCheck("oob_write_addr1", 4'd1, 8'h11);
        readCheck("oob_write_addr9", 4'd9, 8'h00);
        for (int a = 0; a < HEIGHT; a++) readCheck($sformatf("oob_isolation_addr%0d", a), 4'(a), model[a]);

        // 5. we=0 for several cycles leaves the addressed entry alone.
        @(negedge clk);
        applyStimulus(1'b0, 4'd2, 8'h00, 4'd2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("we_low_hold_addr2", 8'h12);

        // 6. Reset pulse between clock edges clears immediately and blocks writes.
        @(negedge clk);
        raddr = 4'd4;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_immediate_addr4", 8'h00);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        applyStimulus(1'b1, 4'd5, 8'h77, 4'd5);
        @(posedge clk);
        #2;
        checkOutput("write_blocked_in_reset", 8'h00);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd5);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int a = 0; a < HEIGHT; a++) readCheck($sformatf("post_pulse_addr%0d", a), 4'(a), 8'h00);

        // Normal writes resume after reset is released.
        applyStimulus(1'b1, 4'd6, 8'h3C, 4'd6);
        @(posedge clk);
        @(negedge clk);
        readCheck("resume_write_addr6", 4'd6, 8'h3C);
        readCheck("resume_isolation_addr7", 4'd7, 8'h00);

        // Drain: every queued expectation must have been consumed by the monitor.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
